// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - two-port instruction-memory arbiter with debug starvation guard (optional IMEM_ARB_ALIGN_CHK_EN)
module imem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_rd,
  output logic        align_err
);

  typedef enum logic {
    FETCH_PRI = 1'b0,
    DBG_FORCE = 1'b1
  } state_t;

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_starve_cnt;
  logic [3:0]  w_starve_nxt;
  logic        r_f_rvalid;
  logic        r_d_rvalid;
  logic [31:0] r_f_rdata;
  logic [31:0] r_d_rdata;
  logic        w_f_gnt;
  logic        w_d_gnt;
  logic [31:0] w_gnt_addr;

  // Grant selection, starvation counter and next state; grants are masked while in reset
  always_comb begin
    w_f_gnt      = 1'b0;
    w_d_gnt      = 1'b0;
    w_starve_nxt = r_starve_cnt;
    w_state_nxt  = r_state;
    if (reset_n) begin
      case (r_state)
        FETCH_PRI: begin
          if (f_req)      w_f_gnt = 1'b1;
          else if (d_req) w_d_gnt = 1'b1;
        end
        DBG_FORCE: begin
          if (d_req)      w_d_gnt = 1'b1;
          else if (f_req) w_f_gnt = 1'b1;
        end
        default: ;
      endcase
    end
    if (!d_req || w_d_gnt)          w_starve_nxt = 4'd0;
    else if (r_starve_cnt != 4'hF)  w_starve_nxt = r_starve_cnt + 4'd1;
    case (r_state)
      FETCH_PRI: if (w_starve_nxt >= LP_LIMIT) w_state_nxt = DBG_FORCE;
      DBG_FORCE: if (w_d_gnt || !d_req)        w_state_nxt = FETCH_PRI;
      default:   w_state_nxt = FETCH_PRI;
    endcase
  end

  assign f_gnt      = w_f_gnt;
  assign d_gnt      = w_d_gnt;
  // With no grant the fetch address is presented so the memory sees a stable address
  assign w_gnt_addr = w_d_gnt ? d_addr : f_addr;

`ifdef IMEM_ARB_ALIGN_CHK_EN
  logic r_align_err;
  assign imem_a = {w_gnt_addr[31:2], 2'b00};

  // Misalignment flag travels with the response pulse and is clear otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_align_err <= 1'b0;
    else          r_align_err <= (w_f_gnt || w_d_gnt) && (w_gnt_addr[1:0] != 2'b00);
  end
  assign align_err = r_align_err;
`else
  assign imem_a    = w_gnt_addr;
  assign align_err = 1'b0;
`endif

  // FSM state and starvation counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= FETCH_PRI;
      r_starve_cnt <= 4'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // One-cycle read response; data holds between pulses, reset drops any pending response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_f_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_f_rdata  <= 32'd0;
      r_d_rdata  <= 32'd0;
    end else begin
      r_f_rvalid <= w_f_gnt;
      r_d_rvalid <= w_d_gnt;
      if (w_f_gnt) r_f_rdata <= imem_rd;
      if (w_d_gnt) r_d_rdata <= imem_rd;
    end
  end

  assign f_rvalid = r_f_rvalid;
  assign d_rvalid = r_d_rvalid;
  assign f_rdata  = r_f_rdata;
  assign d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed self-checking bench for imem_arbiter
module tb_imem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [31:0] imem_a;
  logic [31:0] imem_rd;
  logic        align_err;

  int n_pass = 0;
  int n_chk  = 0;

  imem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .imem_a(imem_a), .imem_rd(imem_rd), .align_err(align_err)
  );

  assign imem_rd = imem_a + 32'h1000_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; f_req = 1'b1; f_addr = 32'h8; d_req = 1'b1; d_addr = 32'hC;
    #1;
    n_chk++; if (f_gnt !== 1'b0) $display("FAIL rst_f_gnt: got %0h want 0", f_gnt); else n_pass++;
    n_chk++; if (d_gnt !== 1'b0) $display("FAIL rst_d_gnt: got %0h want 0", d_gnt); else n_pass++;
    tick; tick;
    n_chk++; if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0) $display("FAIL rst_rvalid: got %0h/%0h want 0/0", f_rvalid, d_rvalid); else n_pass++;
    n_chk++; if (f_rdata !== 32'd0 || d_rdata !== 32'd0) $display("FAIL rst_rdata: got %0h/%0h want 0/0", f_rdata, d_rdata); else n_pass++;
    n_chk++; if (align_err !== 1'b0) $display("FAIL rst_align: got %0h want 0", align_err); else n_pass++;
    reset_n = 1'b1; d_req = 1'b0;
    #1;
    n_chk++; if (f_gnt !== 1'b1) $display("FAIL first_gnt: got %0h want 1", f_gnt); else n_pass++;
    tick;
    f_req = 1'b0;
    n_chk++; if (f_rvalid !== 1'b1 || f_rdata !== 32'h1000_0008) $display("FAIL pre_rst_resp: got %0h/%0h want 1/10000008", f_rvalid, f_rdata); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_chk++; if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0) $display("FAIL midresp_rvalid: got %0h/%0h want 0/0", f_rvalid, d_rvalid); else n_pass++;
    n_chk++; if (f_rdata !== 32'd0) $display("FAIL midresp_rdata: got %0h want 0", f_rdata); else n_pass++;
    tick;
    reset_n = 1'b1;
    tick;
    n_chk++; if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0) $display("FAIL post_rst_resp: got %0h/%0h want 0/0", f_rvalid, d_rvalid); else n_pass++;
    tick;
    n_chk++; if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0) $display("FAIL post_rst_resp2: got %0h/%0h want 0/0", f_rvalid, d_rvalid); else n_pass++;
  endtask

  task automatic test_fetch_single;
    f_req = 1'b1; f_addr = 32'h0000_0008; d_req = 1'b0;
    #1;
    n_chk++; if (f_gnt !== 1'b1 || d_gnt !== 1'b0) $display("FAIL fetch_gnt: got %0h/%0h want 1/0", f_gnt, d_gnt); else n_pass++;
    n_chk++; if (imem_a !== 32'h0000_0008) $display("FAIL fetch_imem_a: got %0h want 8", imem_a); else n_pass++;
    tick;
    f_req = 1'b0;
    n_chk++; if (f_rvalid !== 1'b1 || d_rvalid !== 1'b0) $display("FAIL fetch_rvalid: got %0h/%0h want 1/0", f_rvalid, d_rvalid); else n_pass++;
    n_chk++; if (f_rdata !== 32'h1000_0008) $display("FAIL fetch_rdata: got %0h want 10000008", f_rdata); else n_pass++;
    n_chk++; if (align_err !== 1'b0) $display("FAIL fetch_align: got %0h want 0", align_err); else n_pass++;
    #1;
    n_chk++; if (f_gnt !== 1'b0) $display("FAIL idle_f_gnt: got %0h want 0", f_gnt); else n_pass++;
    tick;
    n_chk++; if (f_rvalid !== 1'b0) $display("FAIL fetch_pulse: got %0h want 0", f_rvalid); else n_pass++;
    n_chk++; if (f_rdata !== 32'h1000_0008) $display("FAIL fetch_hold: got %0h want 10000008", f_rdata); else n_pass++;
  endtask

  task automatic test_starvation;
    f_req = 1'b1; f_addr = 32'h0000_0020; d_req = 1'b1; d_addr = 32'h0000_000C;
    for (int c = 0; c <= 6; c++) begin
      if (c >= 1 && c <= 4) begin
        n_chk++; if (f_rvalid !== 1'b1 || f_rdata !== 32'h1000_0020) $display("FAIL starve_f_resp c%0d: got %0h/%0h want 1/10000020", c, f_rvalid, f_rdata); else n_pass++;
      end
      if (c == 5) begin
        n_chk++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h1000_000C || f_rvalid !== 1'b0) $display("FAIL starve_d_resp: got %0h/%0h/%0h want 1/1000000c/0", d_rvalid, d_rdata, f_rvalid); else n_pass++;
      end
      if (c == 6) begin
        n_chk++; if (f_rvalid !== 1'b1 || d_rvalid !== 1'b0) $display("FAIL starve_refetch: got %0h/%0h want 1/0", f_rvalid, d_rvalid); else n_pass++;
        break;
      end
      #1;
      if (c == 4) begin
        n_chk++; if (d_gnt !== 1'b1 || f_gnt !== 1'b0 || imem_a !== 32'hC) $display("FAIL starve_force: got %0h/%0h/%0h want 1/0/c", d_gnt, f_gnt, imem_a); else n_pass++;
      end else begin
        n_chk++; if (f_gnt !== 1'b1 || d_gnt !== 1'b0) $display("FAIL starve_f_gnt c%0d: got %0h/%0h want 1/0", c, f_gnt, d_gnt); else n_pass++;
      end
      tick;
    end
    f_req = 1'b0; d_req = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    f_req = 1'b0; d_req = 1'b1; d_addr = 32'h0000_0000;
    #1;
    n_chk++; if (d_gnt !== 1'b1 || f_gnt !== 1'b0) $display("FAIL b2b_gnt0: got %0h/%0h want 1/0", d_gnt, f_gnt); else n_pass++;
    tick;
    d_addr = 32'h0000_0004;
    n_chk++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h1000_0000) $display("FAIL b2b_resp0: got %0h/%0h want 1/10000000", d_rvalid, d_rdata); else n_pass++;
    #1;
    n_chk++; if (d_gnt !== 1'b1 || imem_a !== 32'h4) $display("FAIL b2b_gnt1: got %0h/%0h want 1/4", d_gnt, imem_a); else n_pass++;
    tick;
    d_req = 1'b0;
    n_chk++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h1000_0004) $display("FAIL b2b_resp1: got %0h/%0h want 1/10000004", d_rvalid, d_rdata); else n_pass++;
    tick;
    n_chk++; if (d_rvalid !== 1'b0 || d_rdata !== 32'h1000_0004) $display("FAIL b2b_end: got %0h/%0h want 0/10000004", d_rvalid, d_rdata); else n_pass++;
  endtask

  task automatic test_align;
    logic [31:0] exp_a;
    logic        exp_err;
`ifdef IMEM_ARB_ALIGN_CHK_EN
    exp_a = 32'h0000_0004; exp_err = 1'b1;
`else
    exp_a = 32'h0000_0006; exp_err = 1'b0;
`endif
    f_req = 1'b1; f_addr = 32'h0000_0006; d_req = 1'b0;
    #1;
    n_chk++; if (imem_a !== exp_a) $display("FAIL align_imem_a: got %0h want %0h", imem_a, exp_a); else n_pass++;
    tick;
    f_req = 1'b0;
    n_chk++; if (f_rdata !== exp_a + 32'h1000_0000 || f_rvalid !== 1'b1) $display("FAIL align_rdata: got %0h/%0h want 1/%0h", f_rvalid, f_rdata, exp_a + 32'h1000_0000); else n_pass++;
    n_chk++; if (align_err !== exp_err) $display("FAIL align_err: got %0h want %0h", align_err, exp_err); else n_pass++;
    tick;
    n_chk++; if (align_err !== 1'b0) $display("FAIL align_err_clear: got %0h want 0", align_err); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_fetch_single;
    test_starvation;
    test_back_to_back;
    test_align;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
